dbg_core_agent: RTL

Core-side responder for the debug control interface: it implements the core end of halt/run/step, breakpoint programming and trace streaming. It sits between the debug hub and a core's retirement stage and gates retirement through a retire_allow qualifier. It holds a small exec-breakpoint table and a trace FIFO that streams one record per retired instruction to the hub.

---
 rtl/dbg_core_agent.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/dbg_core_agent.sv
// Core-side debug agent: halt/run/step control, exec breakpoints and a trace FIFO
// that records one entry per retired instruction.
module dbg_core_agent #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned TRACE_W       = 128,
  parameter int unsigned NUM_BP        = 4,
  parameter int unsigned TRACE_DEPTH   = 4,
  parameter bit          HALT_ON_RESET = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               halt_req,
  input  logic               run_req,
  input  logic               step_req,
  output logic               halt_ack,
  output logic               step_ack,
  input  logic               bp_valid,
  input  logic               bp_write,
  input  logic [7:0]         bp_index,
  input  logic [ADDR_W-1:0]  bp_addr,
  input  logic [3:0]         bp_kind,
  input  logic               bp_enable,
  output logic               bp_ready,
  input  logic               trace_en,
  output logic               trace_valid,
  output logic [TRACE_W-1:0] trace_data,
  input  logic               trace_ready,
  input  logic               retire_valid,
  input  logic [ADDR_W-1:0]  retire_pc,
  input  logic [31:0]        retire_insn,
  output logic               retire_allow
);

  localparam int unsigned PtrW = $clog2(TRACE_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StRun, StHalted, StStep} state_e;
  localparam state_e ResetState = HALT_ON_RESET ? StHalted : StRun;

  state_e             state_q, state_d;
  logic               halt_ack_q, halt_ack_d;
  logic               step_ack_q, step_ack_d;
  logic               bp_ready_q;
  logic               skip_q, skip_d;
  logic [31:0]        seq_q, seq_d;
  logic [ADDR_W-1:0]  bp_addr_q [NUM_BP];
  logic [ADDR_W-1:0]  bp_addr_d [NUM_BP];
  logic [3:0]         bp_kind_q [NUM_BP];
  logic [3:0]         bp_kind_d [NUM_BP];
  logic [NUM_BP-1:0]  bp_en_q, bp_en_d;
  logic [TRACE_W-1:0] mem_q [TRACE_DEPTH];
  logic [TRACE_W-1:0] mem_d [TRACE_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [TRACE_W-1:0] trace_data_q, trace_data_d;

  logic               bp_match, bp_hit, fifo_full, fifo_block;
  logic               retire_ev, push, pop;
  logic [TRACE_W-1:0] rec;

  always_comb begin
    bp_match = 1'b0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (bp_en_q[i] && (bp_kind_q[i] == 4'd0) && (bp_addr_q[i] == retire_pc)) bp_match = 1'b1;
    end
  end

  assign bp_hit     = retire_valid && bp_match && !skip_q;
  assign fifo_full  = (count_q == CntW'(TRACE_DEPTH));
  assign fifo_block = trace_en && fifo_full;

  always_comb begin
    unique case (state_q)
      StRun:   retire_allow = !halt_req && !bp_hit && !fifo_block;
      StStep:  retire_allow = !fifo_block;
      default: retire_allow = 1'b0;
    endcase
  end

  assign retire_ev = retire_valid && retire_allow;
  assign push      = retire_ev && trace_en;
  assign pop       = trace_valid && trace_ready;

  always_comb begin
    rec                      = '0;
    rec[ADDR_W-1:0]          = retire_pc;
    rec[ADDR_W+31:ADDR_W]    = retire_insn;
    rec[TRACE_W-1 -: 32]     = seq_q;
  end

  always_comb begin
    state_d    = state_q;
    skip_d     = skip_q;
    step_ack_d = 1'b0;
    if (retire_ev) skip_d = 1'b0;
    unique case (state_q)
      StRun: begin
        if (halt_req || bp_hit) state_d = StHalted;
      end
      StHalted: begin
        if (!halt_req && step_req) state_d = StStep;
        else if (!halt_req && run_req) state_d = StRun;
        if (state_d != StHalted) skip_d = 1'b1;
      end
      default: begin
        if (retire_ev) begin
          state_d    = StHalted;
          step_ack_d = 1'b1;
        end
      end
    endcase
    halt_ack_d = (state_d == StHalted);
    seq_d      = seq_q + 32'(retire_ev);
  end

  always_comb begin
    bp_addr_d = bp_addr_q;
    bp_kind_d = bp_kind_q;
    bp_en_d   = bp_en_q;
    // Out-of-range indices match no entry, so they are accepted without effect.
    if (bp_valid && bp_write) begin
      for (int i = 0; i < NUM_BP; i++) begin
        if ({1'b0, bp_index} == 9'(i)) begin
          bp_addr_d[i] = bp_addr;
          bp_kind_d[i] = bp_kind;
          bp_en_d[i]   = bp_enable;
        end
      end
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    count_d  = count_q + CntW'(push) - CntW'(pop);
    if (push) mem_d[wr_ptr_q] = rec;
    // The new head may be the record written this very cycle.
    if (count_d == '0) trace_data_d = '0;
    else if (push && (wr_ptr_q == rd_ptr_d)) trace_data_d = rec;
    else trace_data_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ResetState;
      halt_ack_q   <= HALT_ON_RESET;
      step_ack_q   <= 1'b0;
      bp_ready_q   <= 1'b0;
      skip_q       <= 1'b0;
      seq_q        <= '0;
      bp_en_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      trace_data_q <= '0;
      for (int i = 0; i < NUM_BP; i++) begin
        bp_addr_q[i] <= '0;
        bp_kind_q[i] <= '0;
      end
      for (int i = 0; i < TRACE_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      halt_ack_q   <= halt_ack_d;
      step_ack_q   <= step_ack_d;
      bp_ready_q   <= 1'b1;
      skip_q       <= skip_d;
      seq_q        <= seq_d;
      bp_addr_q    <= bp_addr_d;
      bp_kind_q    <= bp_kind_d;
      bp_en_q      <= bp_en_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      trace_data_q <= trace_data_d;
    end
  end

  assign halt_ack    = halt_ack_q;
  assign step_ack    = step_ack_q;
  assign bp_ready    = bp_ready_q;
  assign trace_valid = (count_q != '0);
  assign trace_data  = trace_data_q;

endmodule
